// File: rtl/nfi_step_scheduler.sv
// nfi_step_scheduler
//   Paces one-cycle o_go pulses that launch the next Game-of-Life generation.
//   A programmable-rate period counter spaces the pulses while running; a
//   single-step command issues one pulse while paused. Pulses are only issued
//   when the update engine reports it is idle (i_NFI_allowed).
//   Optional feature macro: NFI_GEN_COUNT_EN -- when defined, o_gen_count counts
//   issued gos (wrapping at GEN_W bits); otherwise it is tied to zero.
module nfi_step_scheduler #(
  parameter int BASE_PERIOD  = 4,
  parameter int SPEED_LEVELS = 4,
  parameter int SPEED_RESET  = 0,
  parameter int GEN_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_cmd_toggle_pause,
  input  logic i_cmd_step,
  input  logic i_cmd_speed_up,
  input  logic i_cmd_speed_down,
  input  logic i_NFI_allowed,
  output logic o_go,
  output logic o_paused,
  output logic [((SPEED_LEVELS > 1) ? $clog2(SPEED_LEVELS) : 1)-1:0] o_speed,
  output logic [GEN_W-1:0] o_gen_count
);

  localparam int SPD_W      = (SPEED_LEVELS > 1) ? $clog2(SPEED_LEVELS) : 1;
  localparam int MAX_PERIOD = BASE_PERIOD << (SPEED_LEVELS - 1);
  localparam int CNT_W      = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;
  localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(SPEED_LEVELS - 1);
  localparam logic [SPD_W-1:0] SPD_RST = SPD_W'(SPEED_RESET);

  typedef enum logic [1:0] {
    S_PAUSED = 2'd0,
    S_WAIT   = 2'd1,
    S_ARMED  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] reload_cnt;
  logic [31:0]      period_w;
  logic             pending_q, pending_d;
  logic             go_q, go_d;
  logic [SPD_W-1:0] speed_q, speed_d;

  logic tog_q, step_q, up_q, dn_q;
  logic tog_edge, step_edge, up_edge, dn_edge;

  // A held command level acts only once: edge = level now, low last cycle.
  assign tog_edge  = i_cmd_toggle_pause & ~tog_q;
  assign step_edge = i_cmd_step         & ~step_q;
  assign up_edge   = i_cmd_speed_up     & ~up_q;
  assign dn_edge   = i_cmd_speed_down   & ~dn_q;

  // Period for the current speed; reload is period-1 truncated to the counter width.
  assign period_w   = 32'(BASE_PERIOD) << (SPD_MAX - speed_q);
  assign reload_cnt = CNT_W'(period_w - 32'd1);

  // Command history registers used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_q  <= 1'b0;
      step_q <= 1'b0;
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
    end else begin
      tog_q  <= i_cmd_toggle_pause;
      step_q <= i_cmd_step;
      up_q   <= i_cmd_speed_up;
      dn_q   <= i_cmd_speed_down;
    end
  end

  // Saturating speed selection; simultaneous up and down cancel out.
  always_comb begin
    speed_d = speed_q;
    if (up_edge && !dn_edge && (speed_q != SPD_MAX)) begin
      speed_d = speed_q + SPD_W'(1);
    end else if (dn_edge && !up_edge && (speed_q != '0)) begin
      speed_d = speed_q - SPD_W'(1);
    end
  end

  // Speed register; a change only affects the next counter reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q <= SPD_RST;
    end else begin
      speed_q <= speed_d;
    end
  end

  // FSM state register together with the period counter and step request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_PAUSED;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic: toggle always wins; a step is honoured only while paused.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    unique case (state_q)
      S_PAUSED: begin
        if (tog_edge) begin
          state_d   = S_WAIT;
          cnt_d     = reload_cnt;
          pending_d = 1'b0;
        end else begin
          // A step edge arriving while an earlier step is being issued stays queued.
          pending_d = (pending_q & ~(i_NFI_allowed & ~go_q)) | step_edge;
        end
      end
      S_WAIT: begin
        if (tog_edge) begin
          state_d = S_PAUSED;
        end else if (cnt_q == '0) begin
          state_d = S_ARMED;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ARMED: begin
        if (tog_edge) begin
          state_d = S_PAUSED;
        end else if (i_NFI_allowed) begin
          state_d = S_WAIT;
          cnt_d   = reload_cnt;
        end
      end
      default: begin
        state_d   = S_PAUSED;
        cnt_d     = '0;
        pending_d = 1'b0;
      end
    endcase
  end

  // Output logic: go request; a step go is held off one cycle after any go so
  // o_go can never be high on two consecutive cycles.
  always_comb begin
    go_d = 1'b0;
    unique case (state_q)
      S_PAUSED: go_d = ~tog_edge & pending_q & i_NFI_allowed & ~go_q;
      S_ARMED:  go_d = ~tog_edge & i_NFI_allowed;
      default:  go_d = 1'b0;
    endcase
  end

  // Registered go pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_q <= 1'b0;
    end else begin
      go_q <= go_d;
    end
  end

`ifdef NFI_GEN_COUNT_EN
  logic [GEN_W-1:0] gen_q;

  // Generation counter, advancing in the same cycle the go pulse appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_q <= '0;
    end else if (go_d) begin
      gen_q <= gen_q + GEN_W'(1);
    end
  end

  assign o_gen_count = gen_q;
`else
  assign o_gen_count = '0;
`endif

  assign o_go     = go_q;
  assign o_paused = (state_q == S_PAUSED);
  assign o_speed  = speed_q;

endmodule

// File: tb/tb_nfi_step_scheduler.sv
// Bench for nfi_step_scheduler: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a time-based model.
`timescale 1ns/1ps
module tb_nfi_step_scheduler;

  localparam int TB_BASE   = 4;
  localparam int TB_LEVELS = 4;
  localparam int TB_SPD_W  = 2;
`ifdef NFI_GEN_COUNT_EN
  localparam int TB_GEN_W  = 4;
`else
  localparam int TB_GEN_W  = 16;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] cmd = 4'b0;  // 0 toggle, 1 step, 2 up, 3 down
  logic allowed = 1'b1;
  logic o_go, o_paused;
  logic [TB_SPD_W-1:0] o_speed;
  logic [TB_GEN_W-1:0] o_gen_count;

  int checks = 0;
  int failures = 0;
  int go_total = 0;

  nfi_step_scheduler #(
    .BASE_PERIOD(TB_BASE), .SPEED_LEVELS(TB_LEVELS), .SPEED_RESET(0), .GEN_W(TB_GEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_toggle_pause(cmd[0]), .i_cmd_step(cmd[1]),
    .i_cmd_speed_up(cmd[2]), .i_cmd_speed_down(cmd[3]),
    .i_NFI_allowed(allowed),
    .o_go(o_go), .o_paused(o_paused), .o_speed(o_speed), .o_gen_count(o_gen_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Running: a go becomes eligible at absolute cycle m_ready_at, which is set
  // to (reload cycle + 1 + period). Paused: a step request is served when allowed.
  longint m_cyc, m_ready_at;
  bit     m_go, m_paused, m_pending;
  int     m_speed, m_gen;
  logic [3:0] m_pc;
  bit     prev_go, prev_allowed;

  function automatic longint period_of(input int spd);
    return longint'(TB_BASE) << (TB_LEVELS - 1 - spd);
  endfunction

  task automatic model_reset();
    m_go = 0; m_paused = 1; m_pending = 0; m_speed = 0; m_gen = 0;
    m_pc = 4'b0; m_ready_at = 0;
  endtask

  task automatic model_step();
    logic [3:0] e;
    bit ngo, npaused, npend;
    e = cmd & ~m_pc;
    ngo = 0; npaused = m_paused; npend = m_pending;
    if (m_paused) begin
      if (e[0]) begin
        npaused = 0; npend = 0;
        m_ready_at = m_cyc + 1 + period_of(m_speed);
      end else begin
        if (m_pending && allowed && !m_go) begin ngo = 1; npend = 0; end
        if (e[1]) npend = 1;
      end
    end else if (e[0]) begin
      npaused = 1;
    end else if (m_cyc >= m_ready_at && allowed) begin
      ngo = 1;
      m_ready_at = m_cyc + 1 + period_of(m_speed);
    end
    if (e[2] && !e[3] && m_speed < TB_LEVELS - 1) m_speed++;
    else if (e[3] && !e[2] && m_speed > 0) m_speed--;
`ifdef NFI_GEN_COUNT_EN
    if (ngo) m_gen = (m_gen + 1) % (1 << TB_GEN_W);
`endif
    m_go = ngo; m_paused = npaused; m_pending = npend;
    m_pc = cmd;
    m_cyc++;
  endtask

  // Compare process: every cycle, mid-period, DUT vs model plus pulse invariants.
  initial begin
    model_reset();
    m_cyc = 0; prev_go = 0; prev_allowed = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      check("go", 64'(o_go), 64'(m_go));
      check("paused", 64'(o_paused), 64'(m_paused));
      check("speed", 64'(o_speed), 64'(m_speed));
      check("gen_count", 64'(o_gen_count), 64'(m_gen));
      if (o_go && rst_n) begin
        check("go_is_pulse", 64'(prev_go), 64'(0));
        check("go_is_allowed", 64'(prev_allowed), 64'(1));
      end
      if (o_go) go_total++;
      prev_go = o_go;
      prev_allowed = allowed;
      if (rst_n) model_step();
      else prev_go = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input int which);
    step();
    cmd[which] = 1'b1;
    step();
    cmd[which] = 1'b0;
  endtask

  // Cycles from now until o_go is seen; -1 if not within max_cycles.
  task automatic wait_go(input int max_cycles, output int n);
    bit found;
    found = 0; n = 0;
    while (!found && n < max_cycles) begin
      step();
      n++;
      @(negedge clk);
      if (o_go) found = 1;
    end
    if (!found) n = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, base, found17;
    // 1. reset and idle hold
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    base = go_total;
    run(100);
    check("reset_hold_no_go", 64'(go_total - base), 64'(0));
    @(negedge clk);
    check("reset_paused", 64'(o_paused), 64'(1));
    check("reset_speed", 64'(o_speed), 64'(0));

    // 2. run: first go 33 cycles after the capturing edge, then every 33
    step();
    cmd[0] = 1'b1;
    step();
    cmd[0] = 1'b0;
    @(negedge clk);
    check("run_unpaused", 64'(o_paused), 64'(0));
    wait_go(60, n);
    check("first_go_latency", 64'(n), 64'(33));
    wait_go(60, n);
    check("go_spacing_p32", 64'(n), 64'(33));

    // 3. speed up to the limit
    repeat (3) pulse(2);
    run(2);
    @(negedge clk);
    check("speed_max", 64'(o_speed), 64'(3));
    pulse(2);
    run(2);
    @(negedge clk);
    check("speed_saturate_hi", 64'(o_speed), 64'(3));
    wait_go(80, n);
    wait_go(20, n);
    check("go_spacing_p4_a", 64'(n), 64'(5));
    wait_go(20, n);
    check("go_spacing_p4_b", 64'(n), 64'(5));

    // 4. armed but engine busy
    step();
    allowed = 1'b0;
    base = go_total;
    run(31);
    check("blocked_no_go", 64'(go_total - base), 64'(0));
    allowed = 1'b1;
    @(negedge clk);
    check("allow_rise_same_cycle", 64'(o_go), 64'(0));
    step();
    @(negedge clk);
    check("allow_rise_next_cycle", 64'(o_go), 64'(1));
    step();
    @(negedge clk);
    check("allow_rise_single", 64'(o_go), 64'(0));

    // 5. pause, single steps, step while running
    pulse(0);
    run(5);
    @(negedge clk);
    check("paused_again", 64'(o_paused), 64'(1));
    step();
    base = go_total;
    cmd[1] = 1'b1;
    step();
    cmd[1] = 1'b0;
    run(10);
    check("step_one_go", 64'(go_total - base), 64'(1));
    @(negedge clk);
    check("step_stays_paused", 64'(o_paused), 64'(1));
    step();
    base = go_total;
    cmd[1] = 1'b1;
    run(5);
    cmd[1] = 1'b0;
    run(8);
    check("step_held_one_go", 64'(go_total - base), 64'(1));
    step();
    base = go_total;
    for (int i = 0; i < 20; i++) begin
      cmd[0] = (i == 0);
      cmd[1] = (i == 3);
      step();
    end
    check("step_while_running", 64'(go_total - base), 64'(3));

    // speed down saturation and simultaneous up/down
    repeat (4) pulse(3);
    run(2);
    @(negedge clk);
    check("speed_saturate_lo", 64'(o_speed), 64'(0));
    step();
    cmd[2] = 1'b1;
    cmd[3] = 1'b1;
    step();
    cmd = 4'b0;
    run(2);
    @(negedge clk);
    check("speed_up_down_cancel", 64'(o_speed), 64'(0));
    pulse(2);
    run(1);
    @(negedge clk);
    check("speed_up_one", 64'(o_speed), 64'(1));

    // 6. asynchronous reset while counting, then generation counter wrap
    run(5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_go", 64'(o_go), 64'(0));
    check("async_rst_paused", 64'(o_paused), 64'(1));
    check("async_rst_speed", 64'(o_speed), 64'(0));
    check("async_rst_gen", 64'(o_gen_count), 64'(0));
    step();
    step();
    rst_n = 1'b1;
    pulse(0);
    found17 = 0;
    for (int i = 0; i < 17; i++) begin
      wait_go(40, n);
      if (n > 0) found17++;
    end
    check("seventeen_gos", 64'(found17), 64'(17));
`ifdef NFI_GEN_COUNT_EN
    check("gen_wrap_17", 64'(o_gen_count), 64'(1));
`else
    check("gen_tied_zero", 64'(o_gen_count), 64'(0));
`endif

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      step();
      allowed = ($urandom_range(0, 3) != 0);
      cmd[0]  = ($urandom_range(0, 59) == 0);
      cmd[1]  = ($urandom_range(0, 7) == 0);
      cmd[2]  = ($urandom_range(0, 19) == 0);
      cmd[3]  = ($urandom_range(0, 19) == 0);
      rst_n   = ($urandom_range(0, 999) != 0);
    end
    step();
    rst_n = 1'b1;
    cmd = 4'b0;
    run(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
